// File: rtl/fetch_pc_if.sv
// Fetch-stage control and status bundle between the decode/control side and the PC unit.
interface fetch_pc_if;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchImm;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        JumpReg;
  logic [31:0] RegTarget;
  logic [31:0] PCAddress;
  logic [31:0] PCPlus4;
  logic        Halted;
  logic        Fault;
  logic [31:0] FaultAddr;
  logic [31:0] InstrCount;

  modport master (
    output Stall, BranchTaken, BranchImm, Jump, JumpIndex, JumpReg, RegTarget,
    input  PCAddress, PCPlus4, Halted, Fault, FaultAddr, InstrCount
  );

  modport slave (
    input  Stall, BranchTaken, BranchImm, Jump, JumpIndex, JumpReg, RegTarget,
    output PCAddress, PCPlus4, Halted, Fault, FaultAddr, InstrCount
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter / next-PC selection with halt (self-loop) detection,
// illegal-fetch fault capture and a saturating retired-instruction counter.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 512
) (
  input  logic       Clk,
  input  logic       Reset,
  fetch_pc_if.slave  bus
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic [31:0]        pc_plus4;
  logic signed [31:0] br_off;
  logic [31:0]        br_tgt;
  logic [31:0]        jmp_tgt;
  logic [31:0]        npc;
  logic               sel_branch;
  logic               npc_illegal;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{bus.BranchImm[15]}}, bus.BranchImm, 2'b00};
  assign br_tgt   = pc_plus4 + $unsigned(br_off);
  assign jmp_tgt  = {pc_plus4[31:28], bus.JumpIndex, 2'b00};

  // Priority: jr over j/jal over taken branch over sequential.
  always_comb begin
    npc        = pc_plus4;
    sel_branch = 1'b0;
    if (bus.JumpReg) begin
      npc = bus.RegTarget;
    end else if (bus.Jump) begin
      npc = jmp_tgt;
    end else if (bus.BranchTaken) begin
      npc        = br_tgt;
      sel_branch = 1'b1;
    end
  end

  assign npc_illegal = (npc[1:0] != 2'b00) || (npc >= IMEM_LIMIT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_cnt_d  = instr_cnt_q;
    fault_addr_d = fault_addr_q;
    if (state_q == S_RUN && !bus.Stall) begin
      if (npc_illegal) begin
        fault_addr_d = npc;
        state_d      = S_FAULT;
      end else if (sel_branch && (br_tgt == pc_q)) begin
        instr_cnt_d = sat_inc(instr_cnt_q);
        state_d     = S_HALT;
      end else begin
        pc_d        = npc;
        instr_cnt_d = sat_inc(instr_cnt_q);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      instr_cnt_q  <= 32'd0;
      fault_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_cnt_q  <= instr_cnt_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign bus.PCAddress  = pc_q;
  assign bus.PCPlus4    = pc_plus4;
  assign bus.Halted     = (state_q == S_HALT);
  assign bus.Fault      = (state_q == S_FAULT);
  assign bus.FaultAddr  = fault_addr_q;
  assign bus.InstrCount = instr_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed scoreboard bench for fetch_pc_unit: stimulus queues expected state, a negedge monitor checks it.
module tb_fetch_pc_unit;

  logic Clk;
  logic Reset;

  fetch_pc_if bus ();

  fetch_pc_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (512)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        halted;
    logic        fault;
    logic [31:0] faddr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: registered outputs are stable at the falling edge.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.PCAddress !== e.pc || bus.PCPlus4 !== e.pc + 32'd4 ||
          bus.InstrCount !== e.cnt || bus.Halted !== e.halted ||
          bus.Fault !== e.fault || bus.FaultAddr !== e.faddr) begin
        errors++;
        $display("FAIL %s: got pc=%h pc4=%h cnt=%h halt=%b fault=%b faddr=%h, want pc=%h pc4=%h cnt=%h halt=%b fault=%b faddr=%h",
                 e.name, bus.PCAddress, bus.PCPlus4, bus.InstrCount, bus.Halted, bus.Fault, bus.FaultAddr,
                 e.pc, e.pc + 32'd4, e.cnt, e.halted, e.fault, e.faddr);
      end
    end
  end

  task automatic drive(input logic st, input logic bt, input logic [15:0] imm,
                       input logic j, input logic [25:0] idx,
                       input logic jr, input logic [31:0] rt);
    bus.Stall       = st;
    bus.BranchTaken = bt;
    bus.BranchImm   = imm;
    bus.Jump        = j;
    bus.JumpIndex   = idx;
    bus.JumpReg     = jr;
    bus.RegTarget   = rt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
  endtask

  task automatic step(input string nm, input logic [31:0] pc, input logic [31:0] cnt,
                      input logic h, input logic f, input logic [31:0] fa);
    exp_t e;
    @(posedge Clk);
    #1;
    e.name = nm; e.pc = pc; e.cnt = cnt; e.halted = h; e.fault = f; e.faddr = fa;
    exp_q.push_back(e);
  endtask

  initial begin
    Reset = 1'b0;
    idle();

    // Reset and sequential fetch
    step("reset0", 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
    step("reset1", 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
    Reset = 1'b1;
    step("seq4", 32'h4, 32'd1, 1'b0, 1'b0, 32'h0);
    step("seq8", 32'h8, 32'd2, 1'b0, 1'b0, 32'h0);
    step("seqC", 32'hC, 32'd3, 1'b0, 1'b0, 32'h0);

    // Branch and jump-over-branch priority
    drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h17, 1'b0, 32'h0);
    step("jmp5C", 32'h5C, 32'd4, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 16'hFFF2, 1'b0, 26'h0, 1'b0, 32'h0);
    step("br28", 32'h28, 32'd5, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h17, 1'b0, 32'h0);
    step("jmp5C_b", 32'h5C, 32'd6, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 16'hFFF2, 1'b1, 26'h10, 1'b0, 32'h0);
    step("jmp_wins", 32'h40, 32'd7, 1'b0, 1'b0, 32'h0);

    // Stall holds PC and count, discards the branch
    drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h4, 1'b0, 32'h0);
    step("jmp10", 32'h10, 32'd8, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 16'h5, 1'b0, 26'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step("stall", 32'h10, 32'd8, 1'b0, 1'b0, 32'h0);
    idle();
    step("unstall", 32'h14, 32'd9, 1'b0, 1'b0, 32'h0);

    // Self-loop halt, absorbing, reset exits
    drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h24, 1'b0, 32'h0);
    step("jmp90", 32'h90, 32'd10, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0, 26'h0, 1'b0, 32'h0);
    step("halt", 32'h90, 32'd11, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b0, 32'h0);
    step("halt_jmp", 32'h90, 32'd11, 1'b1, 1'b0, 32'h0);
    Reset = 1'b0;
    step("halt_reset", 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
    Reset = 1'b1;

    // Misaligned jr faults; fault is absorbing
    drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b1, 32'h202);
    step("fault202", 32'h0, 32'd0, 1'b0, 1'b1, 32'h202);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b0, 32'h0);
    step("fault_hold", 32'h0, 32'd0, 1'b0, 1'b1, 32'h202);
    Reset = 1'b0;
    step("fault_reset", 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
    Reset = 1'b1;

    // Boundary: 0x200 illegal, 0x1FC legal, sequential past end faults
    drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h200);
    step("fault200", 32'h0, 32'd0, 1'b0, 1'b1, 32'h200);
    Reset = 1'b0;
    step("reset2", 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
    Reset = 1'b1;
    drive(1'b0, 1'b1, 16'h7, 1'b1, 26'h10, 1'b1, 32'h8);
    step("jr_wins", 32'h8, 32'd1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h1FC);
    step("jr1FC", 32'h1FC, 32'd2, 1'b0, 1'b0, 32'h0);
    idle();
    step("seq_off_end", 32'h1FC, 32'd2, 1'b0, 1'b1, 32'h200);
    Reset = 1'b0;
    step("reset3", 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
    Reset = 1'b1;

    // Counter saturation
    drive(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    step("sat_stall", 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
    @(negedge Clk);
    #1;
    dut.instr_cnt_q = 32'hFFFF_FFFE;
    step("sat_preload", 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    idle();
    step("sat1", 32'h4, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    step("sat2", 32'h8, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    step("sat3", 32'hC, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and next-PC stage that sits directly upstream of the 128-word instruction memory.
- Drives the instruction-fetch address each cycle.
- Selects sequential, branch, jump or register-jump targets.
- Detects the program's terminal self-loop (halt) and illegal fetch addresses (fault), and counts retired instructions.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_BYTES, 512, instruction memory size in bytes (128 words); a fetch address >= this value is illegal.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset.
- Stall  input  1  hold PC and all state this cycle.
- BranchTaken  input  1  current instruction is a taken conditional branch.
- BranchImm  input  16  raw branch immediate (word offset, signed).
- Jump  input  1  current instruction is j/jal.
- JumpIndex  input  26  jump instruction index field.
- JumpReg  input  1  current instruction is jr.
- RegTarget  input  32  register value for jr.
- PCAddress  output  32  current PC; drives instruction memory Address.
- PCPlus4  output  32  PCAddress + 4 (combinational).
- Halted  output  1  high in HALT state.
- Fault  output  1  high in FAULT state.
- FaultAddr  output  32  rejected next-PC value, captured on fault entry.
- InstrCount  output  32  retired-instruction counter.

Behaviour:
- Reset (Reset==0 at a rising edge):
  - PCAddress=RESET_PC, InstrCount=0, FaultAddr=0, Halted=0, Fault=0, state=RUN.
  - Reset overrides every other input and works from any state, including mid-halt or mid-fault.
- States and transitions:
  - RUN -> HALT on a detected self-loop.
  - RUN -> FAULT on an illegal next PC.
  - HALT and FAULT are absorbing; only Reset exits them.
- Target formation, all 32-bit, wrap modulo 2^32:
  - BT = PCPlus4 + (sign_extend(BranchImm) << 2).
  - JT = {PCPlus4[31:28], JumpIndex, 2'b00}.
  - RT = RegTarget.
- Next-PC priority: JumpReg > Jump > BranchTaken > PCPlus4. Lower-priority requests in the same cycle are ignored.
- Per-cycle update in RUN with Stall==0; retirement occurs only here:
  - If the next PC is illegal (NPC[1:0]!=0, or NPC >= IMEM_BYTES): FaultAddr<=NPC, PC unchanged, InstrCount unchanged, state<=FAULT.
  - Else if BranchTaken is selected and BT==PCAddress (self-loop): PC unchanged, InstrCount+1, state<=HALT.
  - Else: PC<=NPC, InstrCount+1.
- Stall==1 in RUN: PC, InstrCount and state hold. Branch/jump inputs are ignored that cycle and must be re-presented.
- HALT/FAULT: PC, InstrCount and FaultAddr frozen. All inputs except Reset ignored. PCAddress keeps presenting the frozen address.
- InstrCount saturates at 32'hFFFFFFFF (no wrap).
- Latency:
  - A redirect presented in cycle N appears on PCAddress after the edge ending cycle N (one cycle).
  - PCPlus4 follows PCAddress combinationally.
- Halted and Fault are registered state decodes, asserted the cycle after the triggering edge.

Test Plan:
- Reset low for 2 edges, release, 3 idle cycles -> PCAddress 0x0, 0x4, 0x8, 0xC; InstrCount=3; Halted=0, Fault=0.
- Branch: at PC 0x5C, BranchTaken=1, BranchImm=16'hFFF2 -> next PC 0x28; Jump=1 with JumpIndex=0x10 at the same time -> PC 0x40 (jump wins).
- Self-loop: at PC 0x90, BranchTaken=1, BranchImm=16'hFFFF -> PC stays 0x90; Halted=1 next cycle; InstrCount+1; later Jump=1 has no effect; then Reset=0 -> PC=0x0, Halted=0.
- Stall: Stall=1 for 4 cycles with BranchTaken=1 at PC 0x10 -> PC stays 0x10 and InstrCount unchanged; Stall=0 with no branch -> PC 0x14.
- Faults:
  - JumpReg=1, RegTarget=0x202 -> Fault=1, FaultAddr=0x202, PC unchanged.
  - After reset, JumpReg=1, RegTarget=0x200 -> Fault=1, FaultAddr=0x200.
  - After reset, RegTarget=0x1FC -> PC=0x1FC, no fault.
- Saturation: force InstrCount to 32'hFFFFFFFE (bench preload via hierarchical deposit), run 3 cycles -> InstrCount holds 32'hFFFFFFFF.
